// File: rtl/fft_host_ctrl.sv
// fft_host_ctrl: sequences one FFT frame through an external FFT core.
// Loads N_POINTS samples from the s stream, waits for the core to finish,
// then reads the result RAM through a 2-entry buffer onto the m stream.
// Outputs are forced low while rst_i is high so the reset values hold
// even before the first reset edge has cleared the state.

module fft_host_ctrl #(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        s_valid_i,
  input  logic [DATA_W-1:0]           s_data_i,
  output logic                        s_ready_o,
  output logic                        fft_start_o,
  output logic                        fft_wr_o,
  output logic [DATA_W-1:0]           fft_wdata_o,
  output logic                        fft_end_samples_o,
  input  logic                        fft_done_i,
  output logic                        fft_read_ram_o,
  output logic [$clog2(N_POINTS)-1:0] ram_addr_o,
  input  logic [DATA_W-1:0]           ram_rdata_i,
  output logic                        m_valid_o,
  output logic [DATA_W-1:0]           m_data_o,
  input  logic                        m_ready_i,
  output logic                        busy_o,
  output logic                        frame_done_o
);

  localparam int ADDR_W = $clog2(N_POINTS);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(N_POINTS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_DONE = 3'd2,
    READOUT   = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  state_t              state_q;
  logic [ADDR_W:0]     smp_cnt_q;     // samples accepted in this frame
  logic [ADDR_W:0]     out_cnt_q;     // results handed downstream
  logic [ADDR_W-1:0]   addr_q;        // next result RAM read address
  logic                inflight_q;    // a read was issued last cycle
  logic [DATA_W-1:0]   fifo_mem_q [2];
  logic                fifo_wr_ptr_q;
  logic                fifo_rd_ptr_q;
  logic [1:0]          fifo_cnt_q;
  logic [1:0]          fifo_cnt_d;

  logic                load_phase_s;
  logic                read_phase_s;
  logic                s_fire_s;
  logic                m_valid_s;
  logic                m_fire_s;
  logic                push_s;
  logic [1:0]          occ_s;
  logic                issue_s;
  logic                last_result_s;

  assign load_phase_s  = (state_q == IDLE) || (state_q == LOAD);
  assign read_phase_s  = (state_q == READOUT) || (state_q == DRAIN);

  // s stream handshake: the sample goes straight through to the core
  assign s_ready_o         = !rst_i && load_phase_s;
  assign s_fire_s          = s_valid_i && s_ready_o;
  assign fft_wr_o          = s_fire_s;
  assign fft_wdata_o       = s_fire_s ? s_data_i : {DATA_W{1'b0}};
  assign fft_start_o       = s_fire_s && (state_q == IDLE);
  assign fft_end_samples_o = s_fire_s && (smp_cnt_q == LAST_CNT);

  // m stream is driven from the buffer head
  assign m_valid_s = !rst_i && (fifo_cnt_q != 2'd0);
  assign m_valid_o = m_valid_s;
  assign m_data_o  = m_valid_s ? fifo_mem_q[fifo_rd_ptr_q] : {DATA_W{1'b0}};
  assign m_fire_s  = m_valid_s && m_ready_i;

  // Occupancy after this cycle's pop plus the read already in flight; a new
  // read is only launched if its data is guaranteed a free slot.
  assign push_s  = inflight_q;
  assign occ_s   = fifo_cnt_q - {1'b0, m_fire_s} + {1'b0, inflight_q};
  assign issue_s = !rst_i && (state_q == READOUT) && (occ_s < 2'd2);

  assign last_result_s  = m_fire_s && (state_q == DRAIN) && (out_cnt_q == LAST_CNT);
  assign frame_done_o   = last_result_s;
  assign fft_read_ram_o = !rst_i && read_phase_s;
  assign ram_addr_o     = rst_i ? {ADDR_W{1'b0}} : addr_q;
  assign busy_o         = !rst_i && (state_q != IDLE);

  // Next buffer occupancy from simultaneous push and pop
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push_s, m_fire_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Frame FSM, counters, read pipeline and result buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      smp_cnt_q     <= '0;
      out_cnt_q     <= '0;
      addr_q        <= '0;
      inflight_q    <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_fire_s) begin
            smp_cnt_q <= CNT_ONE;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (s_fire_s) begin
            if (smp_cnt_q == LAST_CNT) begin
              smp_cnt_q <= '0;
              state_q   <= WAIT_DONE;
            end else begin
              smp_cnt_q <= smp_cnt_q + CNT_ONE;
            end
          end
        end
        WAIT_DONE: begin
          if (fft_done_i) begin
            addr_q    <= '0;
            out_cnt_q <= '0;
            state_q   <= READOUT;
          end
        end
        READOUT: begin
          if (issue_s) begin
            addr_q <= addr_q + ADDR_ONE;
            if (addr_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_result_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      inflight_q <= issue_s;

      if (last_result_s) begin
        out_cnt_q <= '0;
      end else if (m_fire_s && read_phase_s) begin
        out_cnt_q <= out_cnt_q + CNT_ONE;
      end

      if (push_s) begin
        fifo_mem_q[fifo_wr_ptr_q] <= ram_rdata_i;
        fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
      end
      if (m_fire_s) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_host_ctrl.sv
// Directed testbench for fft_host_ctrl (N_POINTS=16, DATA_W=32).
// Inputs change on the falling edge; outputs are observed 1 ns later.
// The result RAM model returns 0x100+addr one cycle after the address.

module tb_fft_host_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_valid_i = 1'b0;
  logic [31:0] s_data_i = 32'd0;
  logic        s_ready_o;
  logic        fft_start_o;
  logic        fft_wr_o;
  logic [31:0] fft_wdata_o;
  logic        fft_end_samples_o;
  logic        fft_done_i = 1'b0;
  logic        fft_read_ram_o;
  logic [3:0]  ram_addr_o;
  logic [31:0] ram_rdata_i = 32'd0;
  logic        m_valid_o;
  logic [31:0] m_data_o;
  logic        m_ready_i = 1'b1;
  logic        busy_o;
  logic        frame_done_o;

  int checks = 0;
  int failures = 0;

  fft_host_ctrl #(.N_POINTS(16), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .fft_start_o(fft_start_o), .fft_wr_o(fft_wr_o), .fft_wdata_o(fft_wdata_o),
    .fft_end_samples_o(fft_end_samples_o), .fft_done_i(fft_done_i),
    .fft_read_ram_o(fft_read_ram_o), .ram_addr_o(ram_addr_o), .ram_rdata_i(ram_rdata_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  // result RAM model: one cycle read latency
  always @(posedge clk_i) ram_rdata_i <= 32'h100 + {28'd0, ram_addr_o};

  // activity recorder
  int          cyc = 0;
  int          start_cnt = 0;
  int          end_idx = -1;
  int          fd_cnt = 0;
  logic [31:0] fd_data = 32'd0;
  logic [31:0] wr_q[$];
  logic [31:0] res_q[$];
  int          res_cyc[$];

  always begin
    @(negedge clk_i);
    #2;
    cyc++;
    if (fft_wr_o) begin
      wr_q.push_back(fft_wdata_o);
      if (fft_end_samples_o) end_idx = wr_q.size() - 1;
    end
    if (fft_start_o) start_cnt++;
    if (m_valid_o && m_ready_i) begin
      res_q.push_back(m_data_o);
      res_cyc.push_back(cyc);
    end
    if (frame_done_o) begin
      fd_cnt++;
      fd_data = m_data_o;
    end
  end

  task automatic clear_mon();
    wr_q.delete(); res_q.delete(); res_cyc.delete();
    start_cnt = 0; end_idx = -1; fd_cnt = 0; fd_data = 32'd0;
  endtask

  function automatic int wr_errs();
    int e = 0;
    if (wr_q.size() != 16) return 99;
    for (int k = 0; k < 16; k++) if (wr_q[k] !== 32'hA0 + k) e++;
    return e;
  endfunction

  function automatic int res_errs();
    int e = 0;
    if (res_q.size() != 16) return 99;
    for (int k = 0; k < 16; k++) if (res_q[k] !== 32'h100 + k) e++;
    return e;
  endfunction

  // offer samples first..15 (data 0xA0+k); optional 1,0 valid pattern and
  // an fft_done_i pulse during LOAD
  task automatic load_frame(input int first, input bit gappy, input bit done_in_load, output bit ok);
    int i = first;
    int guard = 0;
    bit v = 1'b1;
    while (i < 16 && guard < 200) begin
      @(negedge clk_i);
      guard++;
      s_valid_i  = v;
      s_data_i   = 32'hA0 + i;
      fft_done_i = done_in_load && !v && (i == 5);
      #1;
      if (s_valid_i && s_ready_o) i++;
      if (gappy) v = !v;
    end
    ok = (i == 16);
    @(negedge clk_i);
    s_valid_i  = 1'b0;
    fft_done_i = 1'b0;
  endtask

  // pulse fft_done_i and collect the frame; with bp, stall 5 cycles after
  // the 4th result and capture the outputs at stall cycles 0 and 4
  task automatic do_readout(input bit bp, output int lat, output bit ok,
                            output logic [31:0] sd0, output logic [31:0] sd4,
                            output logic [3:0] sa0, output logic [3:0] sa4, output logic sv4);
    int hs = 0;
    int stall_left = 0;
    int stall_idx = 0;
    bit stalled = 1'b0;
    lat = -1; ok = 1'b0; sd0 = '0; sd4 = '0; sa0 = '0; sa4 = '0; sv4 = 1'b0;
    @(negedge clk_i);
    fft_done_i = 1'b1;
    m_ready_i  = 1'b1;
    for (int g = 1; g <= 100; g++) begin
      @(negedge clk_i);
      fft_done_i = 1'b0;
      if (stall_left > 0) begin
        m_ready_i = 1'b0;
        stall_left--;
      end else begin
        m_ready_i = 1'b1;
      end
      #1;
      if (m_valid_o && lat < 0) lat = g;
      if (!m_ready_i) begin
        if (stall_idx == 0) begin sd0 = m_data_o; sa0 = ram_addr_o; end
        if (stall_idx == 4) begin sd4 = m_data_o; sa4 = ram_addr_o; sv4 = m_valid_o; end
        stall_idx++;
      end
      if (m_valid_o && m_ready_i) hs++;
      if (frame_done_o) begin
        ok = 1'b1;
        break;
      end
      if (bp && !stalled && hs == 4) begin
        stalled = 1'b1;
        stall_left = 5;
      end
    end
    m_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; s_valid_i = 1'b1; s_data_i = 32'hDEAD_BEEF; m_ready_i = 1'b1; fft_done_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if ({s_ready_o, fft_start_o, fft_wr_o, fft_end_samples_o, fft_read_ram_o, m_valid_o, busy_o, frame_done_o} !== 8'h00)
      begin failures++; $display("FAIL reset_flags: got %b expected 00000000", {s_ready_o, fft_start_o, fft_wr_o, fft_end_samples_o, fft_read_ram_o, m_valid_o, busy_o, frame_done_o}); end
    checks++;
    if (fft_wdata_o !== 32'd0) begin failures++; $display("FAIL reset_wdata: got %h expected 0", fft_wdata_o); end
    checks++;
    if (ram_addr_o !== 4'd0) begin failures++; $display("FAIL reset_addr: got %h expected 0", ram_addr_o); end
    checks++;
    if (m_data_o !== 32'd0) begin failures++; $display("FAIL reset_mdata: got %h expected 0", m_data_o); end
    @(negedge clk_i);
    rst_i = 1'b0; s_valid_i = 1'b0; fft_done_i = 1'b1;
    #1;
    checks++;
    if (s_ready_o !== 1'b1) begin failures++; $display("FAIL idle_ready: got %b expected 1", s_ready_o); end
    @(negedge clk_i);
    fft_done_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_done_ignored: busy got %b expected 0", busy_o); end
  endtask

  task automatic test_full_frame();
    bit ok_l, ok_r; int lat; logic [31:0] d0, d4; logic [3:0] a0, a4; logic v4;
    clear_mon();
    load_frame(0, 1'b0, 1'b0, ok_l);
    #1;
    checks++;
    if ({ok_l, s_ready_o, busy_o, fft_read_ram_o} !== 4'b1010)
      begin failures++; $display("FAIL full_wait_state: got %b expected 1010", {ok_l, s_ready_o, busy_o, fft_read_ram_o}); end
    do_readout(1'b0, lat, ok_r, d0, d4, a0, a4, v4);
    #3;
    checks++;
    if (ok_r !== 1'b1) begin failures++; $display("FAIL full_timeout: got %b expected 1", ok_r); end
    checks++;
    if (start_cnt !== 1) begin failures++; $display("FAIL full_start_cnt: got %0d expected 1", start_cnt); end
    checks++;
    if (wr_errs() !== 0) begin failures++; $display("FAIL full_writes: got %0d errors (%0d writes) expected 0", wr_errs(), wr_q.size()); end
    checks++;
    if (end_idx !== 15) begin failures++; $display("FAIL full_end_samples: got index %0d expected 15", end_idx); end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL full_first_valid: got %0d cycles after done expected 3", lat); end
    checks++;
    if (res_errs() !== 0) begin failures++; $display("FAIL full_results: got %0d errors (%0d results) expected 0", res_errs(), res_q.size()); end
    checks++;
    if (res_q.size() != 16 || res_cyc[15] - res_cyc[0] !== 15)
      begin failures++; $display("FAIL full_stream_rate: got %0d results over span expected 16 over 15 cycles", res_q.size()); end
    checks++;
    if (fd_cnt !== 1 || fd_data !== 32'h10F) begin failures++; $display("FAIL full_frame_done: got %0d pulses data %h expected 1 pulse data 10f", fd_cnt, fd_data); end
  endtask

  task automatic test_gappy();
    bit ok_l, ok_r; int lat; logic [31:0] d0, d4; logic [3:0] a0, a4; logic v4;
    clear_mon();
    load_frame(0, 1'b1, 1'b1, ok_l);
    checks++;
    if (ok_l !== 1'b1) begin failures++; $display("FAIL gappy_load_timeout: got %b expected 1", ok_l); end
    do_readout(1'b0, lat, ok_r, d0, d4, a0, a4, v4);
    #3;
    checks++;
    if (wr_errs() !== 0 || start_cnt !== 1 || end_idx !== 15)
      begin failures++; $display("FAIL gappy_writes: got errs %0d starts %0d end %0d expected 0 1 15", wr_errs(), start_cnt, end_idx); end
    checks++;
    if (res_errs() !== 0 || fd_cnt !== 1) begin failures++; $display("FAIL gappy_results: got errs %0d done %0d expected 0 1", res_errs(), fd_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok_l, ok_r; int lat; logic [31:0] d0, d4; logic [3:0] a0, a4; logic v4;
    clear_mon();
    load_frame(0, 1'b0, 1'b0, ok_l);
    do_readout(1'b1, lat, ok_r, d0, d4, a0, a4, v4);
    #3;
    checks++;
    if (d0 !== 32'h104 || d4 !== 32'h104 || v4 !== 1'b1)
      begin failures++; $display("FAIL bp_hold: got %h/%h valid %b expected 104/104 valid 1", d0, d4, v4); end
    checks++;
    if (a0 !== 4'd6 || a4 !== 4'd6) begin failures++; $display("FAIL bp_addr_stall: got %0d/%0d expected 6/6", a0, a4); end
    checks++;
    if (res_errs() !== 0 || fd_cnt !== 1 || fd_data !== 32'h10F)
      begin failures++; $display("FAIL bp_results: got errs %0d done %0d data %h expected 0 1 10f", res_errs(), fd_cnt, fd_data); end
  endtask

  task automatic test_reset_readout();
    bit ok_l, ok_r, hit; int lat; logic [31:0] d0, d4; logic [3:0] a0, a4; logic v4;
    clear_mon();
    hit = 1'b0;
    load_frame(0, 1'b0, 1'b0, ok_l);
    @(negedge clk_i);
    fft_done_i = 1'b1;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk_i);
      fft_done_i = 1'b0;
      #1;
      if (ram_addr_o == 4'd7) begin
        rst_i = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (hit !== 1'b1) begin failures++; $display("FAIL rst_reach_addr7: got %b expected 1", hit); end
    checks++;
    if ({fft_read_ram_o, m_valid_o, busy_o} !== 3'b000)
      begin failures++; $display("FAIL rst_abort_outputs: got %b expected 000", {fft_read_ram_o, m_valid_o, busy_o}); end
    repeat (5) @(negedge clk_i);
    checks++;
    if (fd_cnt !== 0) begin failures++; $display("FAIL rst_no_frame_done: got %0d expected 0", fd_cnt); end
    clear_mon();
    load_frame(0, 1'b0, 1'b0, ok_l);
    do_readout(1'b0, lat, ok_r, d0, d4, a0, a4, v4);
    #3;
    checks++;
    if (start_cnt !== 1 || wr_errs() !== 0 || end_idx !== 15 || res_errs() !== 0 || fd_cnt !== 1)
      begin failures++; $display("FAIL rst_next_frame: got starts %0d werr %0d end %0d rerr %0d done %0d expected 1 0 15 0 1", start_cnt, wr_errs(), end_idx, res_errs(), fd_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok_l, ok_r; int lat; logic [31:0] d0, d4; logic [3:0] a0, a4; logic v4;
    clear_mon();
    load_frame(0, 1'b0, 1'b0, ok_l);
    do_readout(1'b0, lat, ok_r, d0, d4, a0, a4, v4);
    @(negedge clk_i);
    clear_mon();
    s_valid_i = 1'b1;
    s_data_i  = 32'hA0;
    #1;
    checks++;
    if ({ok_r, fft_start_o, fft_wr_o} !== 3'b111) begin failures++; $display("FAIL b2b_start: got %b expected 111", {ok_r, fft_start_o, fft_wr_o}); end
    load_frame(1, 1'b0, 1'b0, ok_l);
    do_readout(1'b0, lat, ok_r, d0, d4, a0, a4, v4);
    #3;
    checks++;
    if (wr_errs() !== 0 || start_cnt !== 1 || res_errs() !== 0 || fd_cnt !== 1)
      begin failures++; $display("FAIL b2b_frame2: got werr %0d starts %0d rerr %0d done %0d expected 0 1 0 1", wr_errs(), start_cnt, res_errs(), fd_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gappy();
    test_backpressure();
    test_reset_readout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_host_ctrl.md
FFT_HOST_CTRL -- requirements
Module: fft_host_ctrl

Interface
REQ-001 Parameter N_POINTS, default 16, number of FFT points; power of two, at least 4.
REQ-002 Parameter DATA_W, default 32, sample/result word width.
REQ-003 Derived ADDR_W = clog2(N_POINTS).
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 s_valid_i  input  1  input sample valid.
REQ-007 s_data_i  input  DATA_W  input sample.
REQ-008 s_ready_o  output  1  block accepts a sample this cycle.
REQ-009 fft_start_o  output  1  one-cycle start pulse to the FFT core.
REQ-010 fft_wr_o  output  1  sample write strobe to the FFT core.
REQ-011 fft_wdata_o  output  DATA_W  sample forwarded to the FFT core.
REQ-012 fft_end_samples_o  output  1  marks the last sample of a frame.
REQ-013 fft_done_i  input  1  one-cycle pulse from the FFT core: transform complete.
REQ-014 fft_read_ram_o  output  1  level that holds the FFT core in result-readout mode.
REQ-015 ram_addr_o  output  ADDR_W  result RAM read address.
REQ-016 ram_rdata_i  input  DATA_W  result RAM data; valid exactly 1 cycle after the address.
REQ-017 m_valid_o  output  1  result valid.
REQ-018 m_data_o  output  DATA_W  result word.
REQ-019 m_ready_i  input  1  downstream accepts the result.
REQ-020 busy_o  output  1  high in every state except IDLE.
REQ-021 frame_done_o  output  1  one-cycle pulse on the handshake of the last result.

Function
REQ-022 The FSM SHALL have the states IDLE, LOAD, WAIT_DONE, READOUT and DRAIN.
REQ-023 A transfer on the s or m stream SHALL occur only when valid and ready are both high in the same cycle.
REQ-024 IDLE: s_ready_o=1; an accepted sample moves the FSM to LOAD and becomes sample 0.
REQ-025 LOAD: s_ready_o=1; each accepted sample SHALL drive fft_wr_o=1 and fft_wdata_o=s_data_i combinationally in the same cycle.
REQ-026 fft_start_o SHALL be high only in the cycle sample 0 is accepted.
REQ-027 Sample counter: ADDR_W+1 bits; increments per accepted sample.
REQ-028 fft_end_samples_o SHALL be high coincident with acceptance of sample N_POINTS-1; the next state is WAIT_DONE.
REQ-029 WAIT_DONE: s_ready_o=0; stay until fft_done_i=1, then go to READOUT with the read address = 0.
REQ-030 fft_done_i SHALL be ignored in every state except WAIT_DONE.
REQ-031 READOUT and DRAIN: fft_read_ram_o=1; it SHALL be 0 in all other states.
REQ-032 Output buffer: 2-entry FIFO; the m stream is driven from the FIFO head.
REQ-033 A read SHALL be issued in a cycle only if (FIFO occupancy + reads in flight) < 2.
REQ-034 Each issued read SHALL push ram_rdata_i into the FIFO on the following cycle.
REQ-035 ram_addr_o SHALL increment per issued read; after address N_POINTS-1 is issued, go to DRAIN.
REQ-036 DRAIN: no reads issued; after the last result handshake, pulse frame_done_o and return to IDLE in the next cycle.
REQ-037 m_data_o SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-038 With m_ready_i held at 1, results SHALL stream at 1 per cycle; first m_valid_o 2 cycles after entering READOUT.
REQ-039 Results SHALL be delivered in address order 0..N_POINTS-1, none dropped or duplicated.
REQ-040 s_valid_i outside IDLE/LOAD SHALL be ignored (s_ready_o=0).

Reset
REQ-041 rst_i=1 at a clock edge SHALL force IDLE, clear counters, the address and the FIFO, and drop in-flight reads.
REQ-042 Output values during reset: s_ready_o=0, fft_start_o=0, fft_wr_o=0, fft_wdata_o=0, fft_end_samples_o=0, fft_read_ram_o=0, ram_addr_o=0, m_valid_o=0, m_data_o=0, busy_o=0, frame_done_o=0.
REQ-043 Reset mid-LOAD or mid-READOUT SHALL abort the frame with no frame_done_o pulse.
REQ-044 The next frame after reset SHALL start at sample 0.

Verification
REQ-045 Full frame, N=16, s_valid_i always 1, m_ready_i always 1, RAM model returns 0x100+addr:
- one fft_start_o pulse, 16 fft_wr_o strobes, fft_end_samples_o on the 16th;
- after fft_done_i, m_data_o = 0x100..0x10F on consecutive cycles;
- frame_done_o on 0x10F.
REQ-046 Gappy input with s_valid_i toggling 1,0: exactly 16 writes and data order preserved; fft_done_i pulsed during LOAD is ignored.
REQ-047 Backpressure, m_ready_i=0 for 5 cycles mid-readout:
- m_data_o holds its value;
- ram_addr_o stalls once FIFO occupancy + in-flight reads = 2;
- no loss; all 16 results in order.
REQ-048 Reset asserted at readout address 7: next cycle fft_read_ram_o=0, m_valid_o=0, busy_o=0; no frame_done_o pulse.
REQ-049 Back-to-back frames: sample 0 of frame 2 offered in the cycle after frame_done_o; it is accepted with fft_start_o=1.
